// File: rtl/usb_bridge_pkg.sv
// Shared types and helpers for the Avalon-MM to usbHostSlave register bridge.
package usb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Local CSR lives at the all-ones word address.
    function automatic longint unsigned csr_word_addr(input int unsigned aw);
        return (64'd1 << aw) - 64'd1;
    endfunction

    // Sticky timeout flag sits in the top data bit of the CSR.
    function automatic int unsigned csr_flag_bit(input int unsigned dw);
        return dw - 1;
    endfunction

endpackage

// File: rtl/usb_avalon_bridge_irq_agg.sv
// Interrupt mask register, registered masked OR-reduce and sticky timeout flag.
module usb_avalon_bridge_irq_agg
    import usb_bridge_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic [NUM_IRQ-1:0] mask_wen_i,
    input  logic [NUM_IRQ-1:0] mask_wdata_i,
    input  logic               flag_set_i,
    input  logic               flag_clr_i,
    output logic [NUM_IRQ-1:0] mask_o,
    output logic               flag_o,
    output logic               irq_o
);

    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               flag_q, flag_d;
    logic               irq_q, irq_d;

    // A new timeout beats a simultaneous clear.
    always_comb begin
        mask_d = mask_q;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (mask_wen_i[i]) begin
                mask_d[i] = mask_wdata_i[i];
            end
        end
        flag_d = flag_q;
        if (flag_set_i) begin
            flag_d = 1'b1;
        end else if (flag_clr_i) begin
            flag_d = 1'b0;
        end
        irq_d = |(irq_src_i & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '1;
            flag_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            flag_q <= flag_d;
            irq_q  <= irq_d;
        end
    end

    assign mask_o = mask_q;
    assign flag_o = flag_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/usb_avalon_bridge.sv
// Avalon-MM slave that splits wide word accesses into byte-lane strobe/ack
// accesses to the usbHostSlave register port, with ack timeout and irq aggregation.
module usb_avalon_bridge
    import usb_bridge_pkg::*;
#(
    parameter int unsigned AV_DATA_WIDTH   = 32,
    parameter int unsigned CORE_DATA_WIDTH = 8,
    parameter int unsigned CORE_ADDR_WIDTH = 8,
    parameter int unsigned NUM_IRQ         = 9,
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    localparam int unsigned LANES          = AV_DATA_WIDTH / CORE_DATA_WIDTH,
    localparam int unsigned LW             = clog2(LANES),
    localparam int unsigned AV_ADDR_WIDTH  = CORE_ADDR_WIDTH - LW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AV_ADDR_WIDTH-1:0]   address,
    input  logic [AV_DATA_WIDTH-1:0]   writedata,
    input  logic [LANES-1:0]           byteenable,
    input  logic                       write,
    input  logic                       read,
    input  logic                       chipselect,
    output logic [AV_DATA_WIDTH-1:0]   readdata,
    output logic                       waitrequest,
    output logic                       irq,
    output logic [CORE_ADDR_WIDTH-1:0] core_address,
    output logic [CORE_DATA_WIDTH-1:0] core_data_o,
    input  logic [CORE_DATA_WIDTH-1:0] core_data_i,
    output logic                       core_we,
    output logic                       core_strobe,
    input  logic                       core_ack,
    input  logic [NUM_IRQ-1:0]         irq_src
);

    localparam int unsigned LANE_W   = (LW > 0) ? LW : 1;
    localparam int unsigned CNT_W    = clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FLAG_BIT = csr_flag_bit(AV_DATA_WIDTH);
    localparam logic [AV_ADDR_WIDTH-1:0] CSR_ADDR =
        AV_ADDR_WIDTH'(csr_word_addr(AV_ADDR_WIDTH));

    state_e                     state_q, state_d;
    logic [AV_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AV_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0]           be_q, be_d;
    logic                       wr_q, wr_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [AV_DATA_WIDTH-1:0]   rbuf_q, rbuf_d;
    logic [AV_DATA_WIDTH-1:0]   readdata_q, readdata_d;
    logic                       waitrequest_q, waitrequest_d;
    logic                       core_strobe_q, core_strobe_d;
    logic                       core_we_q, core_we_d;
    logic [CORE_ADDR_WIDTH-1:0] core_address_q, core_address_d;
    logic [CORE_DATA_WIDTH-1:0] core_data_o_q, core_data_o_d;

    logic                       req;
    logic                       timeout_hit;
    logic [LANE_W-1:0]          first_lane, next_lane;
    logic                       has_next;
    logic                       csr_wr;
    logic                       flag_set;
    logic [AV_DATA_WIDTH-1:0]   csr_rdata;
    logic [NUM_IRQ-1:0]         mask;
    logic                       flag;
    logic [NUM_IRQ-1:0]         mask_wen;

    // Lowest enabled lane of the incoming request, and next enabled lane above the current one.
    always_comb begin
        first_lane = '0;
        next_lane  = lane_q;
        has_next   = 1'b0;
        for (int i = int'(LANES) - 1; i >= 0; i--) begin
            if (byteenable[i]) begin
                first_lane = LANE_W'(i);
            end
            if (be_q[i] && (i > int'(lane_q))) begin
                next_lane = LANE_W'(i);
                has_next  = 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata                 = '0;
        csr_rdata[NUM_IRQ-1:0]    = mask;
        csr_rdata[FLAG_BIT]       = flag;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            mask_wen[i] = csr_wr & byteenable[i / int'(CORE_DATA_WIDTH)];
        end
    end

    assign req         = chipselect & (read | write);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_d       = wr_q;
        lane_d     = lane_q;
        cnt_d      = cnt_q;
        rbuf_d     = rbuf_q;
        readdata_d = readdata_q;
        csr_wr     = 1'b0;
        flag_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = address;
                    wdata_d = writedata;
                    be_d    = byteenable;
                    wr_d    = write;
                    lane_d  = first_lane;
                    cnt_d   = '0;
                    rbuf_d  = '0;
                    if (byteenable == '0) begin
                        state_d = ST_DONE;
                        if (!write) begin
                            readdata_d = '0;
                        end
                    end else if (address == CSR_ADDR) begin
                        state_d = ST_DONE;
                        if (write) begin
                            csr_wr = 1'b1;
                        end else begin
                            readdata_d = csr_rdata;
                        end
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (core_ack || timeout_hit) begin
                    if (!wr_q) begin
                        rbuf_d[int'(lane_q)*int'(CORE_DATA_WIDTH) +: CORE_DATA_WIDTH] =
                            core_ack ? core_data_i : '1;
                    end
                    flag_set = ~core_ack;
                    if (has_next) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_DONE;
                        if (!wr_q) begin
                            readdata_d = rbuf_d;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                lane_d  = next_lane;
                cnt_d   = '0;
                state_d = ST_ISSUE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Core-side outputs are registered off the next state so they line up with ISSUE.
        waitrequest_d  = (state_d != ST_DONE);
        core_strobe_d  = (state_d == ST_ISSUE);
        core_we_d      = (state_d == ST_ISSUE) & wr_d;
        core_address_d = core_address_q;
        core_data_o_d  = core_data_o_q;
        if (state_d == ST_ISSUE) begin
            core_address_d = (CORE_ADDR_WIDTH'(addr_d) << LW) | CORE_ADDR_WIDTH'(lane_d);
            core_data_o_d  = wdata_d[int'(lane_d)*int'(CORE_DATA_WIDTH) +: CORE_DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            wr_q           <= 1'b0;
            lane_q         <= '0;
            cnt_q          <= '0;
            rbuf_q         <= '0;
            readdata_q     <= '0;
            waitrequest_q  <= 1'b1;
            core_strobe_q  <= 1'b0;
            core_we_q      <= 1'b0;
            core_address_q <= '0;
            core_data_o_q  <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            wr_q           <= wr_d;
            lane_q         <= lane_d;
            cnt_q          <= cnt_d;
            rbuf_q         <= rbuf_d;
            readdata_q     <= readdata_d;
            waitrequest_q  <= waitrequest_d;
            core_strobe_q  <= core_strobe_d;
            core_we_q      <= core_we_d;
            core_address_q <= core_address_d;
            core_data_o_q  <= core_data_o_d;
        end
    end

    usb_avalon_bridge_irq_agg #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_agg (
        .clk          (clk),
        .reset        (reset),
        .irq_src_i    (irq_src),
        .mask_wen_i   (mask_wen),
        .mask_wdata_i (writedata[NUM_IRQ-1:0]),
        .flag_set_i   (flag_set),
        .flag_clr_i   (csr_wr & byteenable[LANES-1] & writedata[FLAG_BIT]),
        .mask_o       (mask),
        .flag_o       (flag),
        .irq_o        (irq)
    );

    assign readdata     = readdata_q;
    assign waitrequest  = waitrequest_q;
    assign core_strobe  = core_strobe_q;
    assign core_we      = core_we_q;
    assign core_address = core_address_q;
    assign core_data_o  = core_data_o_q;

endmodule

// File: tb/tb_usb_avalon_bridge.sv
// Self-checking bench for usb_avalon_bridge: behavioural core model plus word-level reference model.
module tb_usb_avalon_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic        write = 1'b0, read = 1'b0, chipselect = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest, irq;
    logic [7:0]  core_address, core_data_o, core_data_i;
    logic        core_we, core_strobe, core_ack;
    logic [8:0]  irq_src = '0;

    int checks = 0;
    int errors = 0;

    // Core model state
    logic [7:0]  core_mem [256];
    logic [15:0] wlog [$];
    int          strobe_cnt = 0;
    int          gap_viol = 0;
    int          ack_cnt = 0;
    int          ack_delay = 0;
    logic        acked_prev = 1'b0;
    logic        noack_en = 1'b0;
    logic [7:0]  noack_addr = '0;
    logic        force_read = 1'b0;

    // Reference model state
    logic [7:0]  ref_mem [256];
    logic [31:0] last_read = '0;

    always #5 clk = ~clk;

    usb_avalon_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .writedata    (writedata),
        .byteenable   (byteenable),
        .write        (write),
        .read         (read),
        .chipselect   (chipselect),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .irq          (irq),
        .core_address (core_address),
        .core_data_o  (core_data_o),
        .core_data_i  (core_data_i),
        .core_we      (core_we),
        .core_strobe  (core_strobe),
        .core_ack     (core_ack),
        .irq_src      (irq_src)
    );

    assign core_ack = core_strobe && !(noack_en && (core_address == noack_addr)) &&
                      (ack_cnt >= ack_delay);
    assign core_data_i = core_mem[core_address];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) core_mem[i] <= 8'(i * 37 + 5);
        end else if (core_strobe && core_ack && core_we) begin
            core_mem[core_address] <= core_data_o;
        end
        if (!reset && core_strobe && core_ack && core_we) wlog.push_back({core_address, core_data_o});
        if (core_strobe) strobe_cnt <= strobe_cnt + 1;
        if (core_strobe && acked_prev) gap_viol <= gap_viol + 1;
        acked_prev <= core_strobe && core_ack;
        ack_cnt    <= (core_strobe && !core_ack) ? ack_cnt + 1 : 0;
    end

    task automatic do_reset;
        reset = 1'b1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
        last_read = '0;
    endtask

    // One Avalon access; returns readdata at the waitrequest-low cycle and cycles spent stalled.
    task automatic av_xfer(input bit wr, input logic [5:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] rd, output int high);
        @(negedge clk);
        chipselect = 1'b1; write = wr; read = !wr || force_read;
        address = a; writedata = wd; byteenable = be;
        high = 0;
        for (int k = 0; k < 200; k++) begin
            if (!waitrequest) break;
            high++;
            @(negedge clk);
        end
        rd = readdata;
        checks++;
        if (waitrequest) begin
            errors++;
            $display("FAIL xfer_bound a=%h waitrequest still %b after %0d cycles", a, waitrequest, high);
        end
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        int high;
        do_reset();
        checks += 7;
        if (readdata !== 32'h0)   begin errors++; $display("FAIL rst_readdata got=%h exp=0", readdata); end
        if (waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq got=%b exp=1", waitrequest); end
        if (core_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe got=%b exp=0", core_strobe); end
        if (core_we !== 1'b0)     begin errors++; $display("FAIL rst_we got=%b exp=0", core_we); end
        if (core_address !== 8'h0) begin errors++; $display("FAIL rst_caddr got=%h exp=0", core_address); end
        if (core_data_o !== 8'h0) begin errors++; $display("FAIL rst_cdata got=%h exp=0", core_data_o); end
        if (irq !== 1'b0)         begin errors++; $display("FAIL rst_irq got=%b exp=0", irq); end
        av_xfer(1'b0, 6'h3F, 32'h0, 4'hF, rd, high);
        last_read = rd;
        checks += 2;
        if (rd !== 32'h0000_01FF) begin errors++; $display("FAIL rst_csr got=%h exp=000001ff", rd); end
        if (high !== 1) begin errors++; $display("FAIL rst_csr_cycles got=%0d exp=1", high); end
    endtask

    task automatic test_read_full;
        logic [31:0] rd;
        int high, sc, gv;
        av_xfer(1'b1, 6'h02, 32'h4433_2211, 4'hF, rd, high);
        for (int l = 0; l < 4; l++) ref_mem[8 + l] = 8'(8'h11 * (l + 1));
        sc = strobe_cnt; gv = gap_viol;
        av_xfer(1'b0, 6'h02, 32'h0, 4'hF, rd, high);
        last_read = rd;
        checks += 4;
        if (rd !== 32'h4433_2211) begin errors++; $display("FAIL full_rd got=%h exp=44332211", rd); end
        if (high !== 8) begin errors++; $display("FAIL full_rd_cycles got=%0d exp=8", high); end
        if (strobe_cnt - sc !== 4) begin errors++; $display("FAIL full_rd_strobes got=%0d exp=4", strobe_cnt - sc); end
        if (gap_viol !== gv) begin errors++; $display("FAIL full_rd_gap got=%0d exp=%0d", gap_viol, gv); end
    endtask

    task automatic test_write_sparse;
        logic [31:0] rd;
        int high, ws, gv;
        ws = wlog.size(); gv = gap_viol;
        force_read = 1'b1;
        av_xfer(1'b1, 6'h05, 32'hA5B6_C7D8, 4'b0101, rd, high);
        force_read = 1'b0;
        ref_mem[8'h14] = 8'hD8; ref_mem[8'h16] = 8'hB6;
        checks += 4;
        if (wlog.size() - ws !== 2) begin
            errors++; $display("FAIL sparse_wr_count got=%0d exp=2", wlog.size() - ws);
        end else begin
            checks += 2;
            if (wlog[ws] !== 16'h14D8)   begin errors++; $display("FAIL sparse_wr0 got=%h exp=14d8", wlog[ws]); end
            if (wlog[ws+1] !== 16'h16B6) begin errors++; $display("FAIL sparse_wr1 got=%h exp=16b6", wlog[ws+1]); end
        end
        if (gap_viol !== gv) begin errors++; $display("FAIL sparse_gap got=%0d exp=%0d", gap_viol, gv); end
        if (high !== 4) begin errors++; $display("FAIL sparse_cycles got=%0d exp=4", high); end
        if (rd !== last_read) begin errors++; $display("FAIL sparse_hold got=%h exp=%h", rd, last_read); end
    endtask

    task automatic test_be_zero;
        logic [31:0] rd;
        int high, sc;
        sc = strobe_cnt;
        av_xfer(1'b0, 6'h02, 32'h0, 4'h0, rd, high);
        last_read = 32'h0;
        checks += 3;
        if (rd !== 32'h0) begin errors++; $display("FAIL be0_rd got=%h exp=0", rd); end
        if (high !== 1) begin errors++; $display("FAIL be0_cycles got=%0d exp=1", high); end
        if (strobe_cnt !== sc) begin errors++; $display("FAIL be0_strobe got=%0d exp=%0d", strobe_cnt, sc); end
    endtask

    task automatic test_timeout;
        logic [31:0] rd, exp_rd;
        int high, sc;
        noack_en = 1'b1; noack_addr = 8'h0D;
        sc = strobe_cnt;
        av_xfer(1'b0, 6'h03, 32'h0, 4'hF, rd, high);
        noack_en = 1'b0;
        exp_rd = {ref_mem[8'h0F], ref_mem[8'h0E], 8'hFF, ref_mem[8'h0C]};
        last_read = exp_rd;
        checks += 3;
        if (rd !== exp_rd) begin errors++; $display("FAIL tmo_rd got=%h exp=%h", rd, exp_rd); end
        if (high !== 11) begin errors++; $display("FAIL tmo_cycles got=%0d exp=11", high); end
        if (strobe_cnt - sc !== 7) begin errors++; $display("FAIL tmo_strobes got=%0d exp=7", strobe_cnt - sc); end
        av_xfer(1'b0, 6'h3F, 32'h0, 4'hF, rd, high);
        checks++;
        if (rd !== 32'h8000_01FF) begin errors++; $display("FAIL tmo_flag_set got=%h exp=800001ff", rd); end
        av_xfer(1'b1, 6'h3F, 32'h8000_0000, 4'h8, rd, high);
        av_xfer(1'b0, 6'h3F, 32'h0, 4'hF, rd, high);
        last_read = rd;
        checks++;
        if (rd !== 32'h0000_01FF) begin errors++; $display("FAIL tmo_flag_clr got=%h exp=000001ff", rd); end
    endtask

    task automatic test_irq;
        logic [31:0] rd, m, s;
        int high;
        @(negedge clk);
        irq_src = 9'h100;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_pre got=%b exp=0", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq); end
        av_xfer(1'b1, 6'h3F, 32'h0, 4'hF, rd, high);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask0 got=%b exp=0", irq); end
        av_xfer(1'b1, 6'h3F, 32'h0000_0100, 4'b0010, rd, high);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask8 got=%b exp=1", irq); end
        av_xfer(1'b0, 6'h3F, 32'h0, 4'hF, rd, high);
        last_read = rd;
        checks++;
        if (rd !== 32'h0000_0100) begin errors++; $display("FAIL irq_csr got=%h exp=00000100", rd); end
        for (int t = 0; t < 10; t++) begin
            m = $urandom; s = $urandom;
            av_xfer(1'b1, 6'h3F, m & 32'h1FF, 4'hF, rd, high);
            irq_src = s[8:0];
            @(negedge clk);
            checks++;
            if (irq !== |(s[8:0] & m[8:0])) begin
                errors++; $display("FAIL irq_rnd t=%0d got=%b src=%h mask=%h", t, irq, s[8:0], m[8:0]);
            end
        end
        irq_src = '0;
        av_xfer(1'b1, 6'h3F, 32'h1FF, 4'hF, rd, high);
    endtask

    task automatic test_random;
        logic [31:0] rd, exp_rd, wd;
        logic [5:0]  a;
        logic [3:0]  be;
        logic [7:0]  ba;
        logic [15:0] expw [$];
        bit          wr;
        int          high, exp_high, n, d, ws;
        for (int t = 0; t < 40; t++) begin
            a = 6'($urandom_range(0, 62)); be = 4'($urandom); wr = 1'($urandom);
            wd = $urandom; d = $urandom_range(0, 2);
            ack_delay = d;
            expw.delete(); exp_rd = '0; n = 0; exp_high = 1;
            for (int l = 0; l < 4; l++) begin
                if (be[l]) begin
                    ba = {a, 2'(l)};
                    n++;
                    exp_high += d + 1;
                    if (wr) begin
                        expw.push_back({ba, wd[8*l +: 8]});
                        ref_mem[ba] = wd[8*l +: 8];
                    end else begin
                        exp_rd[8*l +: 8] = ref_mem[ba];
                    end
                end
            end
            if (n > 1) exp_high += n - 1;
            if (wr) exp_rd = last_read;
            ws = wlog.size();
            av_xfer(wr, a, wd, be, rd, high);
            last_read = exp_rd;
            checks += 3;
            if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rd t=%0d wr=%0d be=%h got=%h exp=%h", t, wr, be, rd, exp_rd); end
            if (high !== exp_high) begin errors++; $display("FAIL rnd_cycles t=%0d got=%0d exp=%0d", t, high, exp_high); end
            if (wlog.size() - ws !== expw.size()) begin
                errors++; $display("FAIL rnd_wcount t=%0d got=%0d exp=%0d", t, wlog.size() - ws, expw.size());
            end else begin
                for (int k = 0; k < expw.size(); k++) begin
                    checks++;
                    if (wlog[ws+k] !== expw[k]) begin
                        errors++; $display("FAIL rnd_wr t=%0d k=%0d got=%h exp=%h", t, k, wlog[ws+k], expw[k]);
                    end
                end
            end
        end
        ack_delay = 0;
    endtask

    task automatic test_abandon;
        int ws, k;
        ws = wlog.size();
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 6'h10; writedata = 32'h0102_0304; byteenable = 4'hF;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        for (k = 0; k < 50; k++) begin
            if (!waitrequest) break;
            @(negedge clk);
        end
        for (int l = 0; l < 4; l++) ref_mem[8'h40 + l] = 8'(4 - l);
        checks += 2;
        if (waitrequest) begin errors++; $display("FAIL abandon_done waitrequest=%b after %0d", waitrequest, k); end
        if (wlog.size() - ws !== 4) begin
            errors++; $display("FAIL abandon_wcount got=%0d exp=4", wlog.size() - ws);
        end else begin
            checks++;
            if (wlog[ws+3] !== 16'h4301) begin errors++; $display("FAIL abandon_last got=%h exp=4301", wlog[ws+3]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        int high;
        av_xfer(1'b1, 6'h3F, 32'h0, 4'hF, rd, high);
        noack_en = 1'b1; noack_addr = 8'h04;
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 6'h01; byteenable = 4'hF;
        repeat (2) @(negedge clk);
        checks++;
        if (core_strobe !== 1'b1) begin errors++; $display("FAIL mid_strobe_pre got=%b exp=1", core_strobe); end
        reset = 1'b1; chipselect = 1'b0; read = 1'b0;
        @(negedge clk);
        checks += 3;
        if (core_strobe !== 1'b0) begin errors++; $display("FAIL mid_strobe got=%b exp=0", core_strobe); end
        if (waitrequest !== 1'b1) begin errors++; $display("FAIL mid_waitreq got=%b exp=1", waitrequest); end
        if (readdata !== 32'h0) begin errors++; $display("FAIL mid_readdata got=%h exp=0", readdata); end
        reset = 1'b0; noack_en = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
        av_xfer(1'b0, 6'h3F, 32'h0, 4'hF, rd, high);
        checks++;
        if (rd !== 32'h0000_01FF) begin errors++; $display("FAIL mid_mask got=%h exp=000001ff", rd); end
        av_xfer(1'b0, 6'h01, 32'h0, 4'hF, rd, high);
        checks++;
        if (rd !== {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]}) begin
            errors++; $display("FAIL mid_recover got=%h", rd);
        end
    endtask

    initial begin
        test_reset();
        test_read_full();
        test_write_sparse();
        test_be_zero();
        test_timeout();
        test_irq();
        test_random();
        test_abandon();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_avalon_bridge.md
Name: usb_avalon_bridge

Overview:
- Parametrised Avalon-MM slave bridge between a wide Avalon bus and the byte-wide strobe/ack register port of the usbHostSlave core.
- Splits each Avalon word access into sequential per-lane core accesses, honouring byteenable.
- Adds an ack timeout with a sticky error flag.
- Aggregates NUM_IRQ core interrupt sources into one registered, maskable irq.
- Sits between the system interconnect and the usbHostSlave core instance.

Parameters:
- AV_DATA_WIDTH, 32: Avalon data width; must be an integer multiple of CORE_DATA_WIDTH.
- CORE_DATA_WIDTH, 8: core register data width.
- CORE_ADDR_WIDTH, 8: core byte address width.
- NUM_IRQ, 9: number of core interrupt sources; must be < AV_DATA_WIDTH.
- TIMEOUT_CYCLES, 255: maximum cycles core_strobe stays high awaiting core_ack; must be >= 1.
- Derived localparams (not overridable):
  - LANES = AV_DATA_WIDTH/CORE_DATA_WIDTH
  - LW = clog2(LANES)
  - AV_ADDR_WIDTH = CORE_ADDR_WIDTH-LW

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  AV_ADDR_WIDTH  Avalon word address
- writedata  in  AV_DATA_WIDTH  Avalon write data
- byteenable  in  LANES  per-lane enable
- write  in  1  Avalon write request
- read  in  1  Avalon read request
- chipselect  in  1  Avalon select
- readdata  out  AV_DATA_WIDTH  Avalon read data
- waitrequest  out  1  Avalon stall
- irq  out  1  aggregated interrupt
- core_address  out  CORE_ADDR_WIDTH  core register address
- core_data_o  out  CORE_DATA_WIDTH  core write data
- core_data_i  in  CORE_DATA_WIDTH  core read data
- core_we  out  1  core write enable
- core_strobe  out  1  core access strobe
- core_ack  in  1  core access acknowledge
- irq_src  in  NUM_IRQ  level interrupt sources from core

Behaviour:
- One clock domain. Reset is synchronous and active-high; ports are named clk and reset.
- Reset values:
  - FSM=IDLE
  - readdata=0, core_strobe=0, core_we=0, core_address=0, core_data_o=0
  - irq=0, mask register=all ones, timeout flag=0
- FSM states: IDLE, ISSUE, GAP, DONE.
- waitrequest = (state!=DONE). It is therefore high in the request cycle, which is Avalon-compliant.
- Request acceptance: in IDLE, req = chipselect & (read|write). On req, latch address, writedata, byteenable and the read/write flag (write wins if both are high). Lane index starts at the lowest set byteenable bit.
- CSR access (address == all ones):
  - Handled locally; takes no core cycles; goes IDLE->DONE.
  - CSR layout: bits [NUM_IRQ-1:0] = irq mask, bit AV_DATA_WIDTH-1 = timeout flag, other bits read 0.
  - Write: updates mask bits whose lane byteenable is set. Writing 1 to the flag bit clears the flag.
  - The CSR shadows the corresponding core addresses.
- byteenable == 0: IDLE->DONE, readdata=0, no core access.
- Core access, ISSUE state:
  - core_strobe=1, core_address={latched address, lane}.
  - core_we = write flag; core_data_o = writedata lane slice.
  - Timeout counter increments each ISSUE cycle.
- On core_ack in ISSUE:
  - For a read, capture core_data_i into the readdata lane.
  - Drop the strobe and move to GAP if further enabled lanes remain, otherwise to DONE.
- On timeout (counter reaches TIMEOUT_CYCLES with no ack):
  - Drop the strobe; read lane = all ones; set timeout flag (sticky).
  - Continue with the next lane exactly as on ack.
- GAP: exactly one cycle with core_strobe=0, so the core can deassert ack. Then advance to the next set lane, clear the counter, and go to ISSUE.
- Lane order: ascending. Lanes with byteenable low are skipped and read as 0.
- DONE: waitrequest=0 for exactly one cycle with readdata valid, then IDLE. readdata holds its value until the next read completes.
- Latency: a full LANES access with single-cycle ack takes 2*LANES cycles before DONE.
- Master deasserting its request mid-transaction: the access still completes; the result is discarded by the master.
- irq: registered each cycle as |(irq_src & mask), so 1-cycle latency. A CSR mask write is effective on the cycle after DONE.
- Timeout flag: a set (new timeout) in the same cycle as a clear takes precedence.
- Reset mid-transaction: core_strobe drops in the next cycle and the FSM returns to IDLE. No partial-result cleanup is required.

Decomposition:
- Shared package usb_bridge_pkg holds:
  - FSM state enum
  - CSR address constant
  - flag bit position
  - clog2 function
- Optional sub-module usb_irq_agg: mask register, registered OR-reduce, timeout-flag sticky logic.
- Lane sequencer FSM stays in the top module.

Test Plan:
- 32-bit read, byteenable=4'hF, address 6'h02; core returns 11,22,33,44 on bytes 08..0B with 1-cycle ack -> readdata=32'h44332211, waitrequest low once, 8 cycles after acceptance.
- Write 32'hA5B6C7D8, byteenable=4'b0101 -> exactly two core writes: addr x0 data D8, addr x2 data B6; GAP cycle between them with strobe low.
- Core never acks on lane 1 of a full read, TIMEOUT_CYCLES=4 -> strobe drops after 4 cycles, lane1 reads FF, CSR bit31=1. Writing 1 to CSR bit31 -> reads 0.
- irq_src=9'h100, reset mask all ones -> irq=1 one cycle later. CSR write mask=0 -> irq=0. Set mask bit8 -> irq=1.
- byteenable=0 read -> DONE next cycle, readdata=0, core_strobe never asserted.
- reset asserted during ISSUE -> next cycle core_strobe=0, waitrequest=1, state IDLE, mask=all ones.
